pkt_arbiter: RTL and testbench

PKT_ARBITER -- requirements
Module: pkt_arbiter

---
 rtl/pkt_arbiter.sv | 92 +++++++++
 tb/tb_pkt_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_arbiter.sv
// pkt_arbiter: round-robin arbiter that grants one whole packet at a time to a shared parser input.
// Define PKT_ARB_LENCHK_EN to compile in the header length check (len_err/err_port).
module pkt_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS*32-1:0]      in_data,
  input  logic [NUM_PORTS-1:0]         in_val,
  output logic [NUM_PORTS-1:0]         in_ready,
  input  logic [NUM_PORTS-1:0]         in_last,
  output logic [31:0]                  out_data,
  output logic                         out_val,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(NUM_PORTS)-1:0] grant_port,
  output logic                         busy,
  output logic                         len_err,
  output logic [$clog2(NUM_PORTS)-1:0] err_port
);
  localparam int PW = $clog2(NUM_PORTS);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_rr_ptr, r_grant_port, w_pick, w_idx;
  logic w_xfer;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk)
    if (reset) begin
      r_rr_ptr     <= '0;
      r_grant_port <= '0;
    end else if (r_state == IDLE && |in_val)
      r_grant_port <= w_pick;
    else if (w_xfer && out_last)
      r_rr_ptr <= (r_grant_port == PW'(NUM_PORTS - 1)) ? '0 : r_grant_port + PW'(1);
  // descending scan so the smallest offset from rr_ptr wins
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % NUM_PORTS);
      if (in_val[w_idx]) w_pick = w_idx;
    end
  end
  always_comb begin
    busy     = r_state == GRANT;
    out_data = busy ? in_data[32*r_grant_port +: 32] : '0;
    out_val  = busy & in_val[r_grant_port];
    out_last = busy & in_last[r_grant_port];
    in_ready = busy ? NUM_PORTS'(out_ready) << r_grant_port : '0;
    w_xfer   = out_val & out_ready;
    w_next   = busy ? ((w_xfer & out_last) ? IDLE : GRANT) : (|in_val ? GRANT : IDLE);
  end
  assign grant_port = r_grant_port;
`ifdef PKT_ARB_LENCHK_EN
  logic          r_first, r_len_err, w_bad;
  logic [15:0]   r_cnt, w_cnt, w_len;
  logic [16:0]   r_exp, w_exp;
  logic [PW-1:0] r_err_port;
  // header fields are taken from the beat in flight so single-beat packets are checked too
  always_comb begin
    w_len = {out_data[23:16], out_data[31:24]};
    w_cnt = r_first ? 16'd1 : (&r_cnt ? r_cnt : r_cnt + 16'd1);
    w_exp = r_first ? (17'(w_len) + 17'd3) >> 2 : r_exp;
    w_bad = w_xfer & out_last & ({1'b0, w_cnt} != w_exp);
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_first    <= 1'b1;
      r_cnt      <= '0;
      r_exp      <= '0;
      r_len_err  <= 1'b0;
      r_err_port <= '0;
    end else begin
      r_len_err <= w_bad;
      if (w_bad) r_err_port <= r_grant_port;
      if (!busy) begin
        r_first <= 1'b1;
        r_cnt   <= '0;
      end else if (w_xfer) begin
        r_first <= 1'b0;
        r_cnt   <= w_cnt;
        r_exp   <= w_exp;
      end
    end
  assign len_err  = r_len_err;
  assign err_port = r_err_port;
`else
  assign len_err  = 1'b0;
  assign err_port = '0;
`endif
endmodule

// File: tb/tb_pkt_arbiter.sv
// tb_pkt_arbiter: directed tests with a packet-queue reference model checked every cycle.
module tb_pkt_arbiter;
  localparam int N = 4;
  localparam int PW = 2;
  logic            clk = 1'b0, reset = 1'b1;
  logic [N*32-1:0] in_data;
  logic [N-1:0]    in_val, in_ready, in_last;
  logic [31:0]     out_data;
  logic            out_val, out_ready, out_last, busy, len_err;
  logic [PW-1:0]   grant_port, err_port;

  pkt_arbiter #(.NUM_PORTS(N)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_val(in_val), .in_ready(in_ready),
    .in_last(in_last), .out_data(out_data), .out_val(out_val), .out_ready(out_ready),
    .out_last(out_last), .grant_port(grant_port), .busy(busy), .len_err(len_err),
    .err_port(err_port)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [32:0] q [N][$];
  logic [N-1:0] en = '1;
  logic ordy = 1'b1;
  bit m_busy, m_lerr, m_first;
  int m_g, m_rr, m_eport, m_cnt, m_exp, lerr_cnt, lerr_port;
  int grant_log[$], grant_cyc[$], end_cyc[$];
  logic [31:0] beat_log[$];
  bit last_log[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int p = 0; p < N; p++) begin
      in_val[p]         = en[p] && q[p].size() > 0;
      in_data[32*p +: 32] = q[p].size() > 0 ? q[p][0][31:0] : 32'h0;
      in_last[p]        = q[p].size() > 0 ? q[p][0][32] : 1'b0;
    end
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1 apply();
  endtask

  task automatic send_pkt(int p, logic [15:0] len, int nb, int tag);
    for (int i = 0; i < nb; i++)
      q[p].push_back({i == nb - 1, i == 0 ? {len[7:0], len[15:8], 16'(tag)} : {8'(tag), 8'(p), 16'(i)}});
  endtask

  function automatic bit pending();
    pending = m_busy;
    for (int p = 0; p < N; p++) if (q[p].size() > 0) pending = 1;
  endfunction

  task automatic wait_done();
    int n = 0;
    while (pending() && n < 400) begin
      tick();
      n++;
    end
    chk("timeout", 32'(n < 400), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant_log.delete(); grant_cyc.delete(); end_cyc.delete();
    beat_log.delete(); last_log.delete();
  endtask

  function automatic int first_req();
    first_req = -1;
    for (int k = N - 1; k >= 0; k--) if (in_val[(m_rr + k) % N]) first_req = (m_rr + k) % N;
  endfunction

  // reference model: whole-packet grants, round-robin from the port after the last winner
  always @(posedge clk) begin
    logic [31:0] d;
    logic l;
    cyc++;
    if (reset) begin
      m_busy = 0; m_g = 0; m_rr = 0; m_lerr = 0; m_eport = 0; m_first = 1; m_cnt = 0;
      for (int p = 0; p < N; p++) q[p].delete();
    end else begin
      m_lerr = 0;
      if (!m_busy) begin
        if (|in_val) begin
          m_g = first_req(); m_busy = 1; m_first = 1; m_cnt = 0;
          grant_log.push_back(m_g); grant_cyc.push_back(cyc);
        end
      end else if (in_val[m_g] && out_ready) begin
        d = q[m_g][0][31:0];
        l = q[m_g][0][32];
        void'(q[m_g].pop_front());
        beat_log.push_back(d); last_log.push_back(l);
        if (m_first) m_exp = ({d[23:16], d[31:24]} + 3) / 4;
        m_first = 0;
        m_cnt++;
        if (l) begin
          m_busy = 0; m_rr = (m_g + 1) % N; end_cyc.push_back(cyc);
`ifdef PKT_ARB_LENCHK_EN
          if (m_cnt != m_exp) begin m_lerr = 1; m_eport = m_g; end
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    er = m_busy ? N'(out_ready) << m_g : '0;
    chk("busy", busy, m_busy);
    chk("out_val", out_val, m_busy && in_val[m_g]);
    chk("in_ready", in_ready, er);
    if (m_busy) chk("grant_port", grant_port, m_g);
    if (m_busy && in_val[m_g]) begin
      chk("out_data", out_data, q[m_g][0][31:0]);
      chk("out_last", out_last, q[m_g][0][32]);
    end
    chk("len_err", len_err, m_lerr);
    chk("err_port", err_port, m_eport);
    if (len_err) begin lerr_cnt++; lerr_port = err_port; end
  end

  initial begin
    int pat[4] = '{1, 0, 0, 1};
    logic [31:0] expd[4] = '{32'h10000007, 32'h07010001, 32'h07010002, 32'h07010003};
    int n;
    apply();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_out_val", out_val, 0); chk("rst_in_ready", in_ready, 0);
    chk("rst_grant", grant_port, 0); chk("rst_len_err", len_err, 0); chk("rst_err_port", err_port, 0);
    do_reset();
    // single 5-beat packet from port 0, header len 20
    send_pkt(0, 16'd20, 5, 12);
    tick();
    @(negedge clk);
    chk("lat_idle", out_val, 0);
    tick();
    @(negedge clk);
    chk("lat_first", out_val, 1); chk("lat_data", out_data, 32'h1400000C);
    wait_done();
    chk("a_beats", beat_log.size(), 5); chk("a_last4", last_log[4], 1); chk("a_last3", last_log[3], 0);
    chk("a_data4", beat_log[4], 32'h0C000004);
    @(negedge clk);
    chk("a_bubble", busy, 0);
    // ports 0,2 together, then 0,1 with rr wrapping
    do_reset();
    send_pkt(0, 16'd8, 2, 1); send_pkt(2, 16'd8, 2, 2);
    wait_done();
    send_pkt(0, 16'd8, 2, 3); send_pkt(1, 16'd8, 2, 4);
    wait_done();
    chk("b_n", grant_log.size(), 4);
    chk("b_g0", grant_log[0], 0); chk("b_g1", grant_log[1], 2);
    chk("b_g2", grant_log[2], 0); chk("b_g3", grant_log[3], 1);
    chk("b_gap", grant_cyc[1] - end_cyc[0], 1);
    // all ports continuously requesting
    do_reset();
    for (int p = 0; p < N; p++) begin send_pkt(p, 16'd8, 2, p); send_pkt(p, 16'd8, 2, p + 8); end
    wait_done();
    chk("c_n", grant_log.size(), 8);
    for (int i = 0; i < 5; i++) chk("c_order", grant_log[i], i % 4);
    for (int i = 0; i < 7; i++) chk("c_gap", grant_cyc[i+1] - end_cyc[i], 1);
    // stalls on both sides mid-packet
    do_reset();
    send_pkt(1, 16'd16, 4, 7);
    n = 0;
    while (pending() && n < 60) begin
      ordy = pat[n % 4][0];
      en[1] = !(n == 3 || n == 4);
      tick();
      n++;
    end
    ordy = 1'b1; en = '1;
    chk("d_timeout", 32'(n < 60), 1);
    chk("d_beats", beat_log.size(), 4);
    chk("d_grants", grant_log.size(), 1);
    for (int i = 0; i < 4; i++) chk("d_data", beat_log[i], expd[i]);
    // reset on beat 3 of 6
    do_reset();
    send_pkt(2, 16'd24, 6, 5);
    n = 0;
    while (beat_log.size() < 2 && n < 40) begin tick(); n++; end
    chk("e_reach", beat_log.size(), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("e_out_val", out_val, 0); chk("e_in_ready", in_ready, 0); chk("e_busy", busy, 0);
    send_pkt(1, 16'd8, 2, 6);
    wait_done();
    chk("e_regrant", grant_log[grant_log.size()-1], 1);
    chk("e_beats", beat_log.size(), 4);
    // length check
    do_reset();
    lerr_cnt = 0; lerr_port = 0;
    send_pkt(3, 16'd43, 10, 9);
    wait_done();
    repeat (2) tick();
    send_pkt(3, 16'd44, 11, 10);
    wait_done();
    repeat (2) tick();
`ifdef PKT_ARB_LENCHK_EN
    chk("f_pulses", lerr_cnt, 1); chk("f_port", lerr_port, 3);
`else
    chk("f_pulses", lerr_cnt, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
